// File: rtl/cordic_input_loader_if.sv
// Handshake and operand bundle between the command source, the CORDIC input loader,
// the CORDIC core and the result output mux.
interface cordic_input_loader_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_mode;
    logic [15:0] cmd_x;
    logic [15:0] cmd_y;
    logic [15:0] cmd_angle;
    logic [15:0] core_x0;
    logic [15:0] core_y0;
    logic [15:0] core_z0;
    logic        core_rotate;
    logic        core_start;
    logic        core_done;
    logic [3:0]  select;
    logic        res_valid;
    logic        res_ready;
    logic        err;

    // The loader is the slave of this bundle; the surrounding system is the master.
    modport slave (
        input  cmd_valid, cmd_mode, cmd_x, cmd_y, cmd_angle, core_done, res_ready,
        output cmd_ready, core_x0, core_y0, core_z0, core_rotate, core_start,
               select, res_valid, err
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_x, cmd_y, cmd_angle, core_done, res_ready,
        input  cmd_ready, core_x0, core_y0, core_z0, core_rotate, core_start,
               select, res_valid, err
    );
endinterface

// File: rtl/cordic_input_loader.sv
// Accepts one-hot CORDIC commands, loads the core's initial vector, supervises the run
// with a timeout, and presents the one-hot result select until downstream consumes it.
module cordic_input_loader #(
    parameter logic [15:0] K       = 16'h009B,
    parameter int          TIMEOUT = 32
) (
    input logic                   clk,
    input logic                   rst,
    cordic_input_loader_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    mode_dec;
    logic [3:0]    mode_sel;
    logic          accept;
    logic          timeout_hit;
    logic          err_nxt;
    logic          err_q;
    logic [15:0]   x0_q;
    logic [15:0]   y0_q;
    logic [15:0]   z0_q;
    logic          rotate_q;

    // Lowest set bit wins, so overlapping mode bits resolve to a single operation.
    always_comb begin
        mode_dec = 4'b0000;
        casez (bus.cmd_mode)
            4'b???1: mode_dec = 4'b0001;
            4'b??10: mode_dec = 4'b0010;
            4'b?100: mode_dec = 4'b0100;
            4'b1000: mode_dec = 4'b1000;
            default: mode_dec = 4'b0000;
        endcase
    end

    assign accept      = bus.cmd_valid && (state == IDLE);
    // core_done is excluded here so a done on the last allowed cycle wins over timeout.
    assign timeout_hit = (state == RUN) && !bus.core_done && (cnt == CW'(TIMEOUT - 1));

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (mode_dec == 4'b0000) err_nxt   = 1'b1;
                    else                     state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = RUN;
            RUN: begin
                if (bus.core_done) begin
                    state_nxt = HOLD;
                end else if (timeout_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (bus.res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: reset is synchronous and clears every register, so a mid-run reset leaves no stale vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state    <= IDLE;
            cnt      <= '0;
            mode_sel <= 4'b0000;
            err_q    <= 1'b0;
            x0_q     <= 16'h0000;
            y0_q     <= 16'h0000;
            z0_q     <= 16'h0000;
            rotate_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;

            if (state == LOAD)     cnt <= '0;
            else if (state == RUN) cnt <= cnt + CW'(1);

            if (accept && (mode_dec != 4'b0000)) begin
                mode_sel <= mode_dec;
                if (mode_dec[0] || mode_dec[1]) begin
                    x0_q     <= K;
                    y0_q     <= 16'h0000;
                    z0_q     <= bus.cmd_angle;
                    rotate_q <= 1'b1;
                end else begin
                    x0_q     <= bus.cmd_x;
                    y0_q     <= bus.cmd_y;
                    z0_q     <= 16'h0000;
                    rotate_q <= 1'b0;
                end
            end
        end
    end

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.core_start  = (state == LOAD);
    assign bus.res_valid   = (state == HOLD);
    assign bus.select      = (state == HOLD) ? mode_sel : 4'b0000;
    assign bus.err         = err_q;
    assign bus.core_x0     = x0_q;
    assign bus.core_y0     = y0_q;
    assign bus.core_z0     = z0_q;
    assign bus.core_rotate = rotate_q;
endmodule

// File: tb/tb_cordic_input_loader.sv
// Self-checking bench for cordic_input_loader: scoreboard of expected core vectors and
// result selects, plus directed illegal-mode, timeout and mid-operation reset scenarios.
module tb_cordic_input_loader;
    localparam logic [15:0] K_VAL = 16'h009B;
    localparam int          TO    = 32;

    typedef struct packed {
        logic [15:0] x0;
        logic [15:0] y0;
        logic [15:0] z0;
        logic        rot;
        logic [3:0]  sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   start_cnt = 0;
    int   err_cnt = 0;
    exp_t sb[$];

    cordic_input_loader_if bus ();

    cordic_input_loader #(.K(K_VAL), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.core_start === 1'b1) start_cnt++;
        if (bus.err === 1'b1)        err_cnt++;
    end

    function automatic exp_t model(input logic [3:0] m, input logic [15:0] x,
                                   input logic [15:0] y, input logic [15:0] a);
        exp_t e;
        e.sel = 4'b0000;
        for (int b = 0; b < 4; b++)
            if (m[b] && (e.sel == 4'b0000)) e.sel[b] = 1'b1;
        if (e.sel[0] || e.sel[1]) begin
            e.x0 = K_VAL; e.y0 = 16'h0000; e.z0 = a; e.rot = 1'b1;
        end else begin
            e.x0 = x; e.y0 = y; e.z0 = 16'h0000; e.rot = 1'b0;
        end
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_cmd(input logic [3:0] m, input logic [15:0] x,
                             input logic [15:0] y, input logic [15:0] a);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = m;
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_angle = a;
    endtask

    // Full transaction: accept, LOAD, done in RUN cycle done_at, HOLD for hold cycles, consume.
    task automatic do_transaction(input string nm, input logic [3:0] m, input logic [15:0] x,
                                  input logic [15:0] y, input logic [15:0] a,
                                  input int done_at, input int hold);
        exp_t e;
        exp_t got;
        int   lat;
        int   e0;
        e0  = err_cnt;
        start_cnt = 0;
        sb.push_back(model(m, x, y, a));
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL %s accept cmd_ready: got %b want 1", nm, bus.cmd_ready);
        end
        drive_cmd(m, x, y, a);
        tick(); lat = 1;
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.core_start !== 1'b1) begin
            errors++; $display("FAIL %s load core_start: got %b want 1", nm, bus.core_start);
        end
        for (int i = 0; i <= done_at; i++) begin
            tick(); lat++;
            checks++;
            if (bus.core_start !== 1'b0 || bus.res_valid !== 1'b0 || bus.select !== 4'b0000) begin
                errors++;
                $display("FAIL %s run%0d start/valid/select: got %b/%b/%b want 0/0/0000",
                         nm, i, bus.core_start, bus.res_valid, bus.select);
            end
            if (i == done_at) bus.core_done = 1'b1;
        end
        tick(); lat++;
        bus.core_done = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b1 || lat != done_at + 3) begin
            errors++;
            $display("FAIL %s res_valid latency: got valid=%b lat=%0d want valid=1 lat=%0d",
                     nm, bus.res_valid, lat, done_at + 3);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++; $display("FAIL %s scoreboard: got empty queue want one entry", nm);
        end else begin
            e   = sb.pop_front();
            got = '{bus.core_x0, bus.core_y0, bus.core_z0, bus.core_rotate, bus.select};
            if (got !== e) begin
                errors++;
                $display("FAIL %s vector x0/y0/z0/rot/sel: got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b",
                         nm, got.x0, got.y0, got.z0, got.rot, got.sel,
                         e.x0, e.y0, e.z0, e.rot, e.sel);
            end
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            checks++;
            if (bus.res_valid !== 1'b1 || bus.select !== e.sel || bus.core_x0 !== e.x0) begin
                errors++;
                $display("FAIL %s hold%0d valid/select/x0: got %b/%b/%h want 1/%b/%h",
                         nm, h, bus.res_valid, bus.select, bus.core_x0, e.sel, e.x0);
            end
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.select !== 4'b0000 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release valid/select/ready: got %b/%b/%b want 0/0000/1",
                     nm, bus.res_valid, bus.select, bus.cmd_ready);
        end
        checks++;
        if (start_cnt != 1 || err_cnt != e0) begin
            errors++;
            $display("FAIL %s pulses start/err: got %0d/%0d want 1/0", nm, start_cnt, err_cnt - e0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_mode = 4'b0000; bus.cmd_x = '0; bus.cmd_y = '0;
        bus.cmd_angle = '0; bus.core_done = 1'b0; bus.res_ready = 1'b0;
        tick(); tick();
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.select !== 4'b0000 ||
            bus.core_start !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset ready/valid/select/start/err: got %b/%b/%b/%b/%b want 1/0/0000/0/0",
                     bus.cmd_ready, bus.res_valid, bus.select, bus.core_start, bus.err);
        end
        checks++;
        if ({bus.core_x0, bus.core_y0, bus.core_z0, bus.core_rotate} !== 49'd0) begin
            errors++;
            $display("FAIL reset vector: got %h/%h/%h/%b want zeros",
                     bus.core_x0, bus.core_y0, bus.core_z0, bus.core_rotate);
        end
        rst = 1'b0;
    endtask

    task automatic test_illegal();
        int e0;
        e0 = err_cnt;
        start_cnt = 0;
        drive_cmd(4'b0000, 16'h1234, 16'h5678, 16'h9ABC);
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.err !== 1'b1 || bus.cmd_ready !== 1'b1 || bus.core_start !== 1'b0) begin
            errors++;
            $display("FAIL illegal err/ready/start: got %b/%b/%b want 1/1/0",
                     bus.err, bus.cmd_ready, bus.core_start);
        end
        tick();
        tick();
        checks++;
        if (bus.err !== 1'b0 || err_cnt - e0 != 1 || start_cnt != 0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal pulses err/errcnt/start/ready: got %b/%0d/%0d/%b want 0/1/0/1",
                     bus.err, err_cnt - e0, start_cnt, bus.cmd_ready);
        end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_cnt;
        drive_cmd(4'b0001, 16'h0000, 16'h0000, 16'h2000);
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
            tick();
            checks++;
            if (bus.err !== 1'b0 || bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL timeout run%0d err/ready: got %b/%b want 0/0", i, bus.err, bus.cmd_ready);
            end
        end
        tick();
        checks++;
        if (bus.err !== 1'b1 || bus.cmd_ready !== 1'b1 || bus.select !== 4'b0000 ||
            bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout expiry err/ready/select/valid: got %b/%b/%b/%b want 1/1/0000/0",
                     bus.err, bus.cmd_ready, bus.select, bus.res_valid);
        end
        tick();
        checks++;
        if (bus.err !== 1'b0 || err_cnt - e0 != 1) begin
            errors++;
            $display("FAIL timeout err pulse: got err=%b count=%0d want 0/1", bus.err, err_cnt - e0);
        end
    endtask

    task automatic test_reset_mid();
        drive_cmd(4'b0100, 16'h0AAA, 16'h0BBB, 16'h0000);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.select !== 4'b0000 ||
            bus.core_x0 !== 16'h0000 || bus.core_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_run ready/valid/select/x0/start: got %b/%b/%b/%h/%b want 1/0/0000/0000/0",
                     bus.cmd_ready, bus.res_valid, bus.select, bus.core_x0, bus.core_start);
        end
        drive_cmd(4'b1000, 16'h0111, 16'h0222, 16'h0000);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b1 || bus.select !== 4'b1000) begin
            errors++;
            $display("FAIL reset_in_hold pre valid/select: got %b/%b want 1/1000", bus.res_valid, bus.select);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.select !== 4'b0000 ||
            bus.core_y0 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_in_hold ready/valid/select/y0: got %b/%b/%b/%h want 1/0/0000/0000",
                     bus.cmd_ready, bus.res_valid, bus.select, bus.core_y0);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] modes [6];
        modes = '{4'b0010, 4'b1000, 4'b1010, 4'b1100, 4'b0001, 4'b0101};
        for (int i = 0; i < 6; i++)
            do_transaction($sformatf("b2b%0d", i), modes[i], 16'($urandom), 16'($urandom),
                           16'($urandom), i % 3, i % 2);
    endtask

    initial begin
        test_reset();
        do_transaction("sin", 4'b0001, 16'h0000, 16'h0000, 16'h1000, 3, 3);
        do_transaction("magnitude", 4'b0100, 16'h0300, 16'h0400, 16'h7777, 1, 1);
        do_transaction("priority_cos", 4'b0110, 16'h0300, 16'h0400, 16'h0800, 0, 0);
        test_illegal();
        test_timeout();
        do_transaction("done_last_cycle", 4'b1000, 16'h0123, 16'h0456, 16'h0000, TO - 1, 0);
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard drain: got %0d entries want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
